// File: rtl/sevenseg_scan_decoder.sv
// sevenseg_scan_decoder
// ---------------------
// Receive side of the seven-segment display path. It samples a multiplexed,
// scanned 7-segment bus, waits for each digit to settle, decodes the glyph to
// a hex nibble plus decimal point, and publishes a complete frame once every
// digit has been captured.
//
// Optional feature macro: SEVENSEG_ALT_GLYPH_EN
//   defined   : glyph 27 decodes to 7 and glyph 6F decodes to 9 (not bad)
//   undefined : both of those glyphs decode as bad with nibble 0
//
// Ports
//   clk        system clock
//   rst        asynchronous active-high reset
//   seg_in     segment lines, bit order Pgfedcba (bit 7 = P, bit 0 = a)
//   dig_en     digit enables, bit i selects digit i
//   hex_out    decoded nibbles, digit i at [4i+3:4i]
//   dp_out     decimal point per digit
//   bad_out    per-digit flag: glyph not in the decode table
//   out_valid  frame available
//   out_ready  consumer accepts frame
//   overrun    1-cycle pulse: pending unaccepted frame was overwritten
//   conflict   1-cycle pulse: stable sample had more than one digit enable
//   state_dbg  current FSM state (0 WAIT, 1 SETTLE, 2 HOLD)
//
// Handshake: a frame transfers on every rising clk edge where out_valid and
// out_ready are both high. While out_valid is high the outputs hold steady;
// a new publish may replace them (flagged by overrun if not yet accepted).
module sevenseg_scan_decoder #(
  parameter int N_DIGITS      = 3,
  parameter int STABLE_CYCLES = 16,
  parameter int ACTIVE_LOW    = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [7:0]            seg_in,
  input  logic [N_DIGITS-1:0]   dig_en,
  output logic [4*N_DIGITS-1:0] hex_out,
  output logic [N_DIGITS-1:0]   dp_out,
  output logic [N_DIGITS-1:0]   bad_out,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  overrun,
  output logic                  conflict,
  output logic [1:0]            state_dbg
);

  localparam int SW = N_DIGITS + 8;
  localparam logic [7:0] CNT_MAX = 8'(STABLE_CYCLES);
  // Pin level meaning "off"; synchroniser resets here so that the conditioned
  // sample starts at all-zero and matches the cleared sample register.
  localparam logic [7:0]          SEG_IDLE = (ACTIVE_LOW != 0) ? 8'hFF : 8'h00;
  localparam logic [N_DIGITS-1:0] DIG_IDLE = (ACTIVE_LOW != 0) ? '1 : '0;
  localparam logic [N_DIGITS-1:0] DIG_ONE  = N_DIGITS'(1);

  typedef enum logic [1:0] {
    ST_WAIT   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_HOLD   = 2'd2
  } state_t;

  state_t state, state_n;

  // ---------------- input conditioning ----------------
  logic [7:0]          seg_s1, seg_s2;
  logic [N_DIGITS-1:0] dig_s1, dig_s2;
  logic [7:0]          seg_c;
  logic [N_DIGITS-1:0] dig_c;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      seg_s1 <= SEG_IDLE;
      seg_s2 <= SEG_IDLE;
      dig_s1 <= DIG_IDLE;
      dig_s2 <= DIG_IDLE;
    end else begin
      seg_s1 <= seg_in;
      seg_s2 <= seg_s1;
      dig_s1 <= dig_en;
      dig_s2 <= dig_s1;
    end
  end

  assign seg_c = (ACTIVE_LOW != 0) ? ~seg_s2 : seg_s2;
  assign dig_c = (ACTIVE_LOW != 0) ? ~dig_s2 : dig_s2;

  // ---------------- stability tracking ----------------
  // samp is the sample currently being timed; cnt is how many consecutive
  // cycles it has been present (1 on the cycle after a change).
  logic [SW-1:0] cur, samp;
  logic [7:0]    cnt;
  logic          changed;

  assign cur     = {dig_c, seg_c};
  assign changed = (cur != samp);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      samp <= '0;
      cnt  <= 8'd0;
    end else if (changed) begin
      samp <= cur;
      cnt  <= 8'd1;
    end else if (cnt < CNT_MAX) begin
      cnt <= cnt + 8'd1;
    end
  end

  // ---------------- FSM ----------------
  logic eval;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_WAIT;
    else     state <= state_n;
  end

  always_comb begin
    state_n = state;
    eval    = 1'b0;
    case (state)
      ST_WAIT: begin
        if (changed) state_n = ST_SETTLE;
      end
      ST_SETTLE: begin
        if (cnt == CNT_MAX) begin
          eval = 1'b1;
          // A change landing on the evaluation cycle starts the next
          // settle period immediately rather than being lost in HOLD.
          state_n = changed ? ST_SETTLE : ST_HOLD;
        end
      end
      ST_HOLD: begin
        if (changed) state_n = ST_SETTLE;
      end
      default: state_n = ST_WAIT;
    endcase
  end

  assign state_dbg = state;

  // ---------------- sample evaluation ----------------
  logic [N_DIGITS-1:0] samp_dig;
  logic [7:0]          samp_seg;
  logic                one_hot, capture, conflict_n;
  logic [4:0]          dec;

  assign samp_dig   = samp[SW-1:8];
  assign samp_seg   = samp[7:0];
  assign one_hot    = (samp_dig != '0) && ((samp_dig & (samp_dig - DIG_ONE)) == '0);
  assign capture    = eval && one_hot;
  assign conflict_n = eval && (samp_dig != '0) && !one_hot;

  // Returns {bad, nibble}.
  function automatic logic [4:0] decode_glyph(input logic [6:0] g);
    logic [4:0] r;
    case (g)
      7'h3F: r = 5'h00;
      7'h06: r = 5'h01;
      7'h5B: r = 5'h02;
      7'h4F: r = 5'h03;
      7'h66: r = 5'h04;
      7'h6D: r = 5'h05;
      7'h7D: r = 5'h06;
      7'h07: r = 5'h07;
      7'h7F: r = 5'h08;
      7'h67: r = 5'h09;
      7'h77: r = 5'h0A;
      7'h7C: r = 5'h0B;
      7'h39: r = 5'h0C;
      7'h5E: r = 5'h0D;
      7'h79: r = 5'h0E;
      7'h71: r = 5'h0F;
`ifdef SEVENSEG_ALT_GLYPH_EN
      7'h27: r = 5'h07;
      7'h6F: r = 5'h09;
`endif
      default: r = 5'h10;
    endcase
    return r;
  endfunction

  assign dec = decode_glyph(samp_seg[6:0]);

  // ---------------- staging ----------------
  logic [4*N_DIGITS-1:0] hex_stage;
  logic [N_DIGITS-1:0]   dp_stage, bad_stage, captured, captured_n;
  logic                  publish;

  assign publish = &captured;

  always_comb begin
    captured_n = publish ? '0 : captured;
    if (capture) captured_n = captured_n | samp_dig;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hex_stage <= '0;
      dp_stage  <= '0;
      bad_stage <= '0;
      captured  <= '0;
    end else begin
      captured <= captured_n;
      for (int i = 0; i < N_DIGITS; i++) begin
        if (capture && samp_dig[i]) begin
          hex_stage[4*i +: 4] <= dec[3:0];
          dp_stage[i]         <= samp_seg[7];
          bad_stage[i]        <= dec[4];
        end
      end
    end
  end

  // ---------------- output frame ----------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hex_out   <= '0;
      dp_out    <= '0;
      bad_out   <= '0;
      out_valid <= 1'b0;
      overrun   <= 1'b0;
      conflict  <= 1'b0;
    end else begin
      overrun  <= 1'b0;
      conflict <= conflict_n;
      if (publish) begin
        hex_out   <= hex_stage;
        dp_out    <= dp_stage;
        bad_out   <= bad_stage;
        out_valid <= 1'b1;
        // Replacing a frame the consumer is accepting this cycle is not a loss.
        overrun   <= out_valid && !out_ready;
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_sevenseg_scan_decoder.sv
module tb_sevenseg_scan_decoder;

  localparam int N  = 3;
  localparam int ST = 16;
  localparam int AL = 1;

  logic         clk = 1'b0;
  logic         rst;
  logic [7:0]   seg_in;
  logic [N-1:0] dig_en;
  logic [4*N-1:0] hex_out;
  logic [N-1:0] dp_out, bad_out;
  logic         out_valid, out_ready, overrun, conflict;
  logic [1:0]   state_dbg;

  sevenseg_scan_decoder #(.N_DIGITS(N), .STABLE_CYCLES(ST), .ACTIVE_LOW(AL)) dut (
    .clk(clk), .rst(rst), .seg_in(seg_in), .dig_en(dig_en),
    .hex_out(hex_out), .dp_out(dp_out), .bad_out(bad_out),
    .out_valid(out_valid), .out_ready(out_ready),
    .overrun(overrun), .conflict(conflict), .state_dbg(state_dbg)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  // ---------------- scoreboard ----------------
  // entry = {hex[11:0], dp[2:0], bad[2:0]}
  logic [17:0] exp_q[$];
  int checks = 0;
  int errors = 0;
  int conflict_cnt = 0;
  int overrun_cnt = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  logic [6:0] glyphs [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                              7'h7F, 7'h67, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

  // Reference decode: {bad, nibble}
  function automatic logic [4:0] model_decode(input logic [6:0] g);
    logic [4:0] r;
    r = 5'h10;
    for (int i = 0; i < 16; i++)
      if (glyphs[i] == g) r = {1'b0, 4'(i)};
`ifdef SEVENSEG_ALT_GLYPH_EN
    if (g == 7'h27) r = 5'h07;
    if (g == 7'h6F) r = 5'h09;
`endif
    return r;
  endfunction

  // gs = {g2, g1, g0}
  function automatic logic [17:0] frame_exp(input logic [20:0] gs, input logic [2:0] dp);
    logic [11:0] hx;
    logic [2:0]  bd;
    logic [4:0]  d;
    for (int i = 0; i < 3; i++) begin
      d = model_decode(gs[7*i +: 7]);
      hx[4*i +: 4] = d[3:0];
      bd[i] = d[4];
    end
    return {hx, dp, bd};
  endfunction

  logic [17:0] mon_e;
  always @(negedge clk) begin
    if (!rst) begin
      if (conflict) conflict_cnt++;
      if (overrun) overrun_cnt++;
      if (out_valid && out_ready) begin
        check("frame_expected", 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0) begin
          mon_e = exp_q.pop_front();
          check("hex_out", 32'(hex_out), 32'(mon_e[17:6]));
          check("dp_out",  32'(dp_out),  32'(mon_e[5:3]));
          check("bad_out", 32'(bad_out), 32'(mon_e[2:0]));
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic drive_raw(input logic [7:0] seg, input logic [2:0] dig);
    seg_in = (AL != 0) ? ~seg : seg;
    dig_en = (AL != 0) ? ~dig : dig;
  endtask

  task automatic hold(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic scan_digit(input int idx, input logic [6:0] g, input logic dp);
    drive_raw({dp, g}, 3'(1 << idx));
    hold(40);
    drive_raw(8'h00, 3'b000);
    hold(10);
  endtask

  task automatic scan_frame(input logic [20:0] gs, input logic [2:0] dp, input bit push);
    if (push) exp_q.push_back(frame_exp(gs, dp));
    for (int i = 0; i < 3; i++) scan_digit(i, gs[7*i +: 7], dp[i]);
  endtask

  // ---------------- stimulus ----------------
  int n;
  int c0, o0;

  initial begin
    rst = 1'b1;
    out_ready = 1'b1;
    drive_raw(8'h00, 3'b000);
    hold(3);
    check("rst_hex", 32'(hex_out), 32'd0);
    check("rst_dp", 32'(dp_out), 32'd0);
    check("rst_bad", 32'(bad_out), 32'd0);
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_overrun", 32'(overrun), 32'd0);
    check("rst_conflict", 32'(conflict), 32'd0);
    rst = 1'b0;
    hold(5);

    // Frame 0,2,F with publish latency measurement on the last digit
    exp_q.push_back(frame_exp({7'h71, 7'h5B, 7'h3F}, 3'b000));
    scan_digit(0, 7'h3F, 1'b0);
    scan_digit(1, 7'h5B, 1'b0);
    drive_raw({1'b0, 7'h71}, 3'b100);
    n = 0;
    while (!out_valid && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    // 2 sync + 1 change detect + (ST-1) count + 1 capture + 1 publish
    check("publish_latency", 32'(n), 32'(ST + 4));
    hold(40 - n);
    drive_raw(8'h00, 3'b000);
    hold(10);

    // Blank glyph on digit 1 with its decimal point lit
    scan_frame({7'h3F, 7'h00, 7'h4F}, 3'b010, 1'b1);

    // Two frames while the consumer stalls: first is overwritten
    o0 = overrun_cnt;
    out_ready = 1'b0;
    scan_frame({7'h4F, 7'h5B, 7'h06}, 3'b000, 1'b0);
    exp_q.push_back(frame_exp({7'h7D, 7'h6D, 7'h66}, 3'b000));
    scan_frame({7'h7D, 7'h6D, 7'h66}, 3'b000, 1'b0);
    check("overrun_once", 32'(overrun_cnt - o0), 32'd1);
    check("stall_valid", 32'(out_valid), 32'd1);
    check("stall_hex", 32'(hex_out), 32'h654);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    check("valid_drop", 32'(out_valid), 32'd0);
    hold(5);

    // Glitch mid-digit, then a conflicting two-digit sample
    c0 = conflict_cnt;
    exp_q.push_back(frame_exp({7'h66, 7'h06, 7'h3F}, 3'b000));
    drive_raw(8'h3F, 3'b001);
    hold(30);
    drive_raw(8'h7F, 3'b001);
    hold(5);
    drive_raw(8'h00, 3'b000);
    hold(10);
    drive_raw(8'h06, 3'b011);
    hold(40);
    drive_raw(8'h00, 3'b000);
    hold(10);
    check("conflict_once", 32'(conflict_cnt - c0), 32'd1);
    check("conflict_no_frame", 32'(out_valid), 32'd0);
    scan_digit(1, 7'h06, 1'b0);
    scan_digit(2, 7'h66, 1'b0);

    // Reset with two digits staged; post-reset scan order 2,0,1
    scan_digit(0, 7'h7F, 1'b0);
    scan_digit(1, 7'h6D, 1'b1);
    rst = 1'b1;
    hold(3);
    check("midrst_valid", 32'(out_valid), 32'd0);
    check("midrst_hex", 32'(hex_out), 32'd0);
    rst = 1'b0;
    hold(5);
    exp_q.push_back(frame_exp({7'h4F, 7'h5B, 7'h06}, 3'b000));
    scan_digit(2, 7'h4F, 1'b0);
    check("no_stale_frame", 32'(out_valid), 32'd0);
    scan_digit(0, 7'h06, 1'b0);
    scan_digit(1, 7'h5B, 1'b0);

    // Alternate glyph 27 on every digit
    scan_frame({7'h27, 7'h27, 7'h27}, 3'b000, 1'b1);

    hold(30);
    check("queue_drained", 32'(exp_q.size()), 32'd0);
    check("total_conflicts", 32'(conflict_cnt), 32'd1);
    check("total_overruns", 32'(overrun_cnt), 32'd1);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
